spi_cfg_master: RTL

SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

---
 rtl/spi_cfg_master_pkg.sv | 22 ++
 rtl/spi_cfg_master_tick.sv | 27 ++
 rtl/spi_cfg_master.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/spi_cfg_master_pkg.sv
// Shared definitions for the SPI configuration master: frame geometry and
// the sequencer state enumeration.
package spi_cfg_master_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 8;
    localparam int DATA_BITS  = FRAME_BITS - ADDR_BITS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Slave select is held low from LEAD through TRAIL.
    function automatic logic cs_active(input state_e s);
        return (s == ST_LEAD) || (s == ST_SHIFT) || (s == ST_TRAIL);
    endfunction

endpackage

// File: rtl/spi_cfg_master_tick.sv
// Half-period timer: free-running modulo-DIV counter with a synchronous
// clear; o_tick marks the last cycle of each half period.
module spi_tick #(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count 0..DIV-1 and wrap; clear restarts the half period from zero.
    always_ff @(posedge i_clk) begin
        if (i_clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/spi_cfg_master.sv
// SPI configuration master: sends one 16-bit {addr, wdata} frame in mode 0,
// MSB first, and captures the last eight received bits as rdata.
module spi_cfg_master
    import spi_cfg_master_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       spics_n,
    output logic       spick,
    output logic       spido,
    input  logic       spidi
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    state_e r_state;
    state_e w_state_nxt;

    logic                  w_tick;
    logic                  w_tick_clr;
    logic                  w_load;
    logic                  w_sample;
    logic                  w_shift;
    logic                  w_spick_nxt;
    logic                  w_end;

    logic [FRAME_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0]  r_rx;
    logic [DATA_BITS-1:0]  r_rdata;
    logic [3:0]            r_bit;
    logic                  r_spics_n;
    logic                  r_spick;
    logic                  r_busy;
    logic                  r_done;

    // The timer is held at zero while idle so LEAD always gets a full half period.
    assign w_tick_clr = rst || (r_state == ST_IDLE);

    spi_tick #(
        .DIV (DIV)
    ) u_tick (
        .i_clk  (fclk),
        .i_clr  (w_tick_clr),
        .o_tick (w_tick)
    );

    // State register.
    always_ff @(posedge fclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle datapath controls; r_spick doubles as the half-period phase.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_sample    = 1'b0;
        w_shift     = 1'b0;
        w_spick_nxt = r_spick;
        w_end       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LEAD;
                    w_load      = 1'b1;
                end
            end
            ST_LEAD: begin
                if (w_tick) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (!r_spick) begin
                        w_spick_nxt = 1'b1;
                        w_sample    = 1'b1;
                    end else begin
                        w_spick_nxt = 1'b0;
                        if (r_bit == LAST_BIT) begin
                            w_state_nxt = ST_TRAIL;
                        end else begin
                            w_shift = 1'b1;
                        end
                    end
                end
            end
            ST_TRAIL: begin
                if (w_tick) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_end       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, derived from the state being entered so they align with it.
    always_ff @(posedge fclk) begin
        if (rst) begin
            r_spics_n <= 1'b1;
            r_spick   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_spics_n <= !cs_active(w_state_nxt);
            r_spick   <= w_spick_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= w_end;
            if (w_end) begin
                r_rdata <= r_rx;
            end
        end
    end

    // Transmit shift register and bit counter; the counter stops at 15 instead of wrapping.
    always_ff @(posedge fclk) begin
        if (rst) begin
            r_shift <= '0;
            r_bit   <= '0;
        end else if (w_load) begin
            r_shift <= {addr, wdata};
            r_bit   <= '0;
        end else if (w_shift) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
            r_bit   <= r_bit + 1'b1;
        end
    end

    // Receive shifter: after 16 samples only the data-phase byte remains.
    always_ff @(posedge fclk) begin
        if (w_sample) begin
            r_rx <= {r_rx[DATA_BITS-2:0], spidi};
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rdata   = r_rdata;
    assign spics_n = r_spics_n;
    assign spick   = r_spick;
    assign spido   = r_shift[FRAME_BITS-1];

endmodule
